// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-fetch handshake between the PC sequencer and instruction memory.
//   fetch_req  : sequencer -> memory, fetch request (held until fetch_ack)
//   fetch_addr : sequencer -> memory, packed 16-bit PC being fetched
//   fetch_ack  : memory -> sequencer, fetch accepted/completed
// Modports:
//   master : the PC sequencer side
//   slave  : the instruction-memory side
// -----------------------------------------------------------------------------
interface pc_sequencer_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the architectural program counter for the fetch side of the CPU.
// The PC is kept in packed 16-bit form: bits 11:10 are always zero and the
// effective 14-bit address is {pc[15:12], pc[9:0]}.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   run        : level; leaves IDLE and keeps the sequencer fetching
//   fetch      : pc_sequencer_if.master (fetch_req / fetch_addr / fetch_ack)
//   next_valid : decoder presents a next-PC decision (honoured only in WAIT)
//   next_op    : 00 sequential, 01 jump, 10 call, 11 return
//   target     : packed jump/call target
//   pc         : current packed PC
//   busy       : high whenever the sequencer is not IDLE
//   stack_err  : sticky return-stack overflow/underflow flag
//   addr_fault : one-cycle pulse when a jump/call target had bits 11:10 set
//
// Parameters:
//   STACK_DEPTH : return-address stack entries (power of two, 2..16)
//   RESET_PC    : PC loaded on reset (bits 11:10 must be 0)
//
// Optional feature (macro PC_SEQ_REL_BRANCH_EN):
//   When defined, a jump whose target[15] is set is a relative branch: the
//   sign-extended target[13:0] is added, modulo 2^14, to the effective
//   address of inc(pc). addr_fault is not raised for relative branches.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int          STACK_DEPTH = 4,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    pc_sequencer_if.master        fetch,
    input  logic                  next_valid,
    input  logic [1:0]            next_op,
    input  logic [15:0]           target,
    output logic [15:0]           pc,
    output logic                  busy,
    output logic                  stack_err,
    output logic                  addr_fault
);

    localparam int           PW      = $clog2(STACK_DEPTH);
    localparam logic [PW:0]  SP_FULL = (PW+1)'(STACK_DEPTH);
    localparam logic [PW:0]  SP_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]  SP_ZERO = {(PW+1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    state_t      state_r;
    logic [15:0] pc_r;
    logic        fetch_req_r;
    logic        busy_r;
    logic        stack_err_r;
    logic        addr_fault_r;
    logic [PW:0] sp_r;
    logic [15:0] stack_r [STACK_DEPTH];

    logic        update_s;
    logic [15:0] pc_inc_s;
    logic [15:0] pc_next_s;
    logic        push_s;
    logic        pop_s;
    logic        err_set_s;
    logic        fault_s;
    logic        stack_full_s;
    logic        stack_empty_s;
    logic [PW:0] sp_dec_s;

    // Effective 14-bit address of a packed PC.
    function automatic logic [13:0] eff_addr(input logic [15:0] p);
        return {p[15:12], p[9:0]};
    endfunction

    // Packed PC of an effective address; bits 11:10 forced to zero.
    function automatic logic [15:0] pack_addr(input logic [13:0] e);
        return {e[13:10], 2'b00, e[9:0]};
    endfunction

    // Sequential successor, wrapping modulo 2^14 in effective space.
    function automatic logic [15:0] inc_pc(input logic [15:0] p);
        return pack_addr(eff_addr(p) + 14'd1);
    endfunction

    // Next-PC decision, stack push/pop and error/fault detection.
    always_comb begin
        update_s      = (state_r == ST_WAIT) && next_valid;
        pc_inc_s      = inc_pc(pc_r);
        stack_full_s  = (sp_r == SP_FULL);
        stack_empty_s = (sp_r == SP_ZERO);
        sp_dec_s      = sp_r - SP_ONE;
        pc_next_s     = pc_r;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        err_set_s     = 1'b0;
        fault_s       = 1'b0;
        if (update_s) begin
            case (next_op)
                2'b00: begin
                    pc_next_s = pc_inc_s;
                end
                2'b01: begin
`ifdef PC_SEQ_REL_BRANCH_EN
                    if (target[15]) begin
                        // 14-bit add wraps naturally, giving the signed offset.
                        pc_next_s = pack_addr(eff_addr(pc_inc_s) + target[13:0]);
                    end else begin
                        pc_next_s = {target[15:12], 2'b00, target[9:0]};
                        fault_s   = |target[11:10];
                    end
`else
                    pc_next_s = {target[15:12], 2'b00, target[9:0]};
                    fault_s   = |target[11:10];
`endif
                end
                2'b10: begin
                    // A full stack drops the push but the call still jumps.
                    pc_next_s = {target[15:12], 2'b00, target[9:0]};
                    fault_s   = |target[11:10];
                    if (stack_full_s) begin
                        err_set_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end
                2'b11: begin
                    // Underflow falls through to the sequential successor.
                    if (stack_empty_s) begin
                        pc_next_s = pc_inc_s;
                        err_set_s = 1'b1;
                    end else begin
                        pc_next_s = stack_r[sp_dec_s[PW-1:0]];
                        pop_s     = 1'b1;
                    end
                end
                default: begin
                    pc_next_s = pc_r;
                end
            endcase
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Control FSM, PC register, stack pointer and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            fetch_req_r  <= 1'b0;
            busy_r       <= 1'b0;
            stack_err_r  <= 1'b0;
            addr_fault_r <= 1'b0;
            sp_r         <= SP_ZERO;
        end else begin
            pc_r         <= pc_next_s;
            addr_fault_r <= fault_s;
            if (err_set_s) begin
                stack_err_r <= 1'b1;
            end
            if (push_s) begin
                sp_r <= sp_r + SP_ONE;
            end else if (pop_s) begin
                sp_r <= sp_dec_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_r     <= ST_FETCH;
                        fetch_req_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // An issued fetch always completes; run is honoured in WAIT.
                    if (fetch.fetch_ack) begin
                        state_r     <= ST_WAIT;
                        fetch_req_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (next_valid) begin
                        state_r     <= ST_FETCH;
                        fetch_req_r <= 1'b1;
                    end else if (!run) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    fetch_req_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Return-address storage; contents need no reset, only the pointer does.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_r[sp_r[PW-1:0]] <= pc_inc_s;
        end
    end

    assign fetch.fetch_req  = fetch_req_r;
    assign fetch.fetch_addr = pc_r;
    assign pc               = pc_r;
    assign busy             = busy_r;
    assign stack_err        = stack_err_r;
    assign addr_fault       = addr_fault_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed scenarios plus randomized cycles against a behavioural model that
// tracks the PC as an effective address with integer arithmetic and the
// return stack as a queue. Outputs are checked 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
    localparam int DEPTH = 4;
`ifdef PC_SEQ_REL_BRANCH_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        next_valid = 1'b0;
    logic [1:0]  next_op = 2'b00;
    logic [15:0] target = 16'h0000;
    logic [15:0] pc;
    logic        busy;
    logic        stack_err;
    logic        addr_fault;

    pc_sequencer_if fif ();

    pc_sequencer #(.STACK_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .fetch      (fif),
        .next_valid (next_valid),
        .next_op    (next_op),
        .target     (target),
        .pc         (pc),
        .busy       (busy),
        .stack_err  (stack_err),
        .addr_fault (addr_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: 0 idle, 1 fetching, 2 waiting for decoder.
    int m_state;
    int m_pc;
    int m_stack[$];
    bit m_err;
    bit m_fault;

    function automatic int eff(input int p);
        return (p / 4096) * 1024 + (p % 1024);
    endfunction

    function automatic int pk(input int e);
        int w;
        w = ((e % 16384) + 16384) % 16384;
        return (w / 1024) * 4096 + (w % 1024);
    endfunction

    function automatic int inc(input int p);
        return pk(eff(p) + 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_stack.delete();
        m_err   = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_next();
        int t;
        t = int'(target);
        m_fault = 1'b0;
        case (m_state)
            0: if (run) m_state = 1;
            1: if (fif.fetch_ack) m_state = 2;
            2: begin
                if (next_valid) begin
                    m_state = 1;
                    case (next_op)
                        2'd0: m_pc = inc(m_pc);
                        2'd1: begin
                            if (REL && t >= 32768) begin
                                m_pc = pk(eff(inc(m_pc)) + (t % 16384));
                            end else begin
                                m_pc = pk(eff(t));
                                m_fault = ((t / 1024) % 4) != 0;
                            end
                        end
                        2'd2: begin
                            if (m_stack.size() < DEPTH) m_stack.push_back(inc(m_pc));
                            else m_err = 1'b1;
                            m_pc = pk(eff(t));
                            m_fault = ((t / 1024) % 4) != 0;
                        end
                        default: begin
                            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                            else begin
                                m_pc = inc(m_pc);
                                m_err = 1'b1;
                            end
                        end
                    endcase
                end else if (!run) begin
                    m_state = 0;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all();
        check_eq("pc", 32'(pc), 32'(m_pc));
        check_eq("fetch_addr", 32'(fif.fetch_addr), 32'(m_pc));
        check_eq("fetch_req", 32'(fif.fetch_req), 32'(m_state == 1));
        check_eq("busy", 32'(busy), 32'(m_state != 0));
        check_eq("stack_err", 32'(stack_err), 32'(m_err));
        check_eq("addr_fault", 32'(addr_fault), 32'(m_fault));
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        next_valid = 1'b0;
        next_op = 2'b00;
        target = 16'h0000;
        fif.fetch_ack = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start();
        run = 1'b1;
        step();
    endtask

    // From FETCH: ack the fetch, then present one decision in WAIT.
    task automatic do_op(input logic [1:0] op, input logic [15:0] tgt);
        fif.fetch_ack = 1'b1;
        step();
        fif.fetch_ack = 1'b0;
        next_valid = 1'b1;
        next_op = op;
        target = tgt;
        step();
        next_valid = 1'b0;
    endtask

    initial begin
        fif.fetch_ack = 1'b0;

        // Reset, start, ack after 3 cycles, then increment boundaries.
        do_reset();
        check_eq("rst_pc", 32'(pc), 32'h0000);
        check_eq("rst_req", 32'(fif.fetch_req), 32'h0);
        start();
        check_eq("t1_req_rise", 32'(fif.fetch_req), 32'h1);
        check_eq("t1_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("t1_req_hold", 32'(fif.fetch_req), 32'h1);
            check_eq("t1_addr_hold", 32'(fif.fetch_addr), 32'h0000);
        end
        do_op(2'b01, 16'h03FF);
        check_eq("t1_req_again", 32'(fif.fetch_req), 32'h1);
        do_op(2'b00, 16'h0000);
        check_eq("inc_carry", 32'(pc), 32'h1000);
        do_op(2'b01, 16'hF3FF);
        do_op(2'b00, 16'h0000);
        check_eq("inc_wrap", 32'(pc), 32'h0000);

        // Call then return.
        do_reset();
        start();
        do_op(2'b01, 16'h0010);
        do_op(2'b10, 16'h2005);
        check_eq("call_pc", 32'(pc), 32'h2005);
        do_op(2'b11, 16'h0000);
        check_eq("ret_pc", 32'(pc), 32'h0011);
        check_eq("ret_err", 32'(stack_err), 32'h0);

        // Overflow after STACK_DEPTH + 1 calls.
        do_reset();
        start();
        for (int i = 0; i < DEPTH; i++) do_op(2'b10, 16'h0100);
        check_eq("ovf_before", 32'(stack_err), 32'h0);
        do_op(2'b10, 16'h0200);
        check_eq("ovf_err", 32'(stack_err), 32'h1);
        check_eq("ovf_pc", 32'(pc), 32'h0200);

        // Underflow.
        do_reset();
        start();
        do_op(2'b01, 16'h0040);
        do_op(2'b11, 16'h0000);
        check_eq("unf_pc", 32'(pc), 32'h0041);
        check_eq("unf_err", 32'(stack_err), 32'h1);

        // Jump with bits 11:10 set.
        do_reset();
        start();
        do_op(2'b01, 16'h0C20);
        check_eq("fault_pc", 32'(pc), 32'h0020);
        check_eq("fault_pulse", 32'(addr_fault), 32'h1);
        step();
        check_eq("fault_drop", 32'(addr_fault), 32'h0);

`ifdef PC_SEQ_REL_BRANCH_EN
        do_reset();
        start();
        do_op(2'b01, 16'h0010);
        do_op(2'b01, 16'h8002);
        check_eq("rel_fwd", 32'(pc), 32'h0013);
        do_op(2'b01, 16'h0010);
        do_op(2'b01, 16'hBFFF);
        check_eq("rel_back", 32'(pc), 32'h0010);
`endif

        // Reset asserted mid-fetch drops fetch_req immediately.
        do_reset();
        start();
        do_op(2'b01, 16'h1234);
        check_eq("mid_req", 32'(fif.fetch_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_req", 32'(fif.fetch_req), 32'h0);
        check_eq("async_pc", 32'(pc), 32'h0000);
        check_eq("async_busy", 32'(busy), 32'h0);

        // Randomized cycles.
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) do_reset();
            run = ($urandom_range(0, 9) != 0);
            fif.fetch_ack = 1'($urandom_range(0, 1));
            next_valid = ($urandom_range(0, 2) != 0);
            next_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) target = 16'($urandom);
            else target = 16'($urandom) & 16'hF3FF;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter owner for the fetch side of the CPU.
- Holds the architectural PC in the packed 16-bit format: bits 11:10 are always 0, and the effective 14-bit address is {PC[15:12], PC[9:0]}.
- Issues instruction fetches over a req/ack handshake.
- Takes the decoder's next-PC decision: sequential, jump, call or return. Call and return use an internal return-address stack.

Parameters:
- STACK_DEPTH, 4, number of return-address stack entries (power of two, 2..16).
- RESET_PC, 16'h0000, PC value loaded on reset; bits 11:10 must be 0.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; leaves IDLE and starts fetching.
- fetch_req  output  1  fetch request to instruction memory.
- fetch_addr  output  16  packed PC being fetched; equal to pc.
- fetch_ack  input  1  memory accepted/completed the fetch.
- next_valid  input  1  decoder presents a next-PC decision this cycle.
- next_op  input  2  00 = sequential, 01 = jump, 10 = call, 11 = return.
- target  input  16  packed jump/call target.
- pc  output  16  current packed PC.
- busy  output  1  high whenever state is not IDLE.
- stack_err  output  1  sticky flag: overflow or underflow occurred.
- addr_fault  output  1  one-cycle pulse when a target had bits 11:10 set.

Behaviour:
- Reset (async, rst_n = 0):
  - pc = RESET_PC, state = IDLE, fetch_req = 0, busy = 0, stack_err = 0, addr_fault = 0.
  - Stack pointer = 0 (empty). Stack contents are don't-care.
- States:
  - IDLE: fetch_req = 0. Moves to FETCH the cycle after run = 1 is sampled.
  - FETCH: fetch_req = 1 and fetch_addr = pc, both held stable until fetch_ack. On fetch_ack, drop fetch_req the next cycle and go to WAIT.
  - WAIT: hold pc. On next_valid = 1, update pc per next_op and go to FETCH the next cycle. If run = 0 while in WAIT with next_valid = 0, go to IDLE.
- A request always completes once issued. run = 0 during FETCH does not abort the fetch; it is honoured in WAIT.
- Increment (inc):
  - Compute ({pc[15:12], pc[9:0]} + 1) mod 2^14 and repack with bits 11:10 = 00.
  - Example: 16'h03FF -> 16'h1000.
  - Wrap: 16'hF3FF -> 16'h0000.
- next_op 00 (sequential): pc <= inc(pc).
- next_op 01 (jump): pc <= {target[15:12], 2'b00, target[9:0]}. If target[11:10] != 0, pulse addr_fault in the update cycle; bits 11:10 are still forced to 0.
- next_op 10 (call):
  - Push inc(pc) and load pc as for jump.
  - If the stack is full, the push is dropped, stack_err is set, and the jump still occurs.
- next_op 11 (return):
  - Pop: pc <= top entry.
  - If the stack is empty, pc <= inc(pc) and stack_err is set.
- Latency:
  - fetch_ack to the next fetch_req is at minimum 2 cycles (ack, WAIT + next_valid same cycle, FETCH).
  - pc changes exactly one clock after next_valid is sampled in WAIT.
- next_valid outside WAIT is ignored.
- stack_err is cleared only by reset.
- Reset asserted mid-fetch drops fetch_req asynchronously.

Optional Feature:
- Macro: PC_SEQ_REL_BRANCH_EN.
- When defined:
  - next_op 01 with target[15] = 1 is a relative branch.
  - Offset = sign-extended target[13:0], added modulo 2^14 to the effective address of inc(pc), then repacked.
  - addr_fault is not checked for relative branches.
- When undefined: next_op 01 is always an absolute jump as above.

Test Plan:
- Reset, run = 1, ack after 3 cycles -> fetch_req rises 1 cycle after run, fetch_addr = 16'h0000 held until ack; busy = 1.
- pc = 16'h03FF, next_op = 00 -> pc = 16'h1000.
- pc = 16'hF3FF, next_op = 00 -> pc = 16'h0000.
- Call to 16'h2005 from pc 16'h0010, then return -> pc = 16'h2005, then 16'h0011; stack_err = 0.
- STACK_DEPTH + 1 calls -> stack_err = 1 after the last call.
- Return on an empty stack from 16'h0040 -> pc = 16'h0041, stack_err = 1.
- Jump with target = 16'h0C20 -> pc = 16'h0020, addr_fault pulses for exactly 1 cycle.
- With PC_SEQ_REL_BRANCH_EN defined, from pc = 16'h0010:
  - target = 16'h8002 -> pc = 16'h0013.
  - target = 16'hBFFF (offset -1) -> pc = 16'h0010.
- rst_n low during FETCH -> fetch_req = 0 immediately; pc = RESET_PC.
